apb_to_obi: RTL and testbench
=============================

# apb_to_obi

APB-subordinate to OBI-manager bridge. It accepts one APB transfer at a time, issues it as a single OBI transaction, then completes the APB access phase with the OBI response. It sits between APB peripherals' masters (debug/test APB ports, external APB initiators) and the OBI crossbar. It is the inverse of the OBI-to-APB adapter.

## Interface
Parameters:
- ObiCfg, obi_pkg::ObiDefaultConfig: OBI manager-port configuration (AddrWidth, DataWidth, IdWidth, UseRReady, OptionalCfg).
- obi_req_t, logic: OBI request struct (manager port, output).
- obi_rsp_t, logic: OBI response struct (manager port, input).
- apb_req_t, logic: APB request struct (subordinate port, input).
- apb_rsp_t, logic: APB response struct (subordinate port, output).
- Aid, '0: constant OBI aid driven on every request (IdWidth bits).

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- apb_req_i  in  apb_req_t  psel, penable, paddr, pwrite, pwdata, pstrb, pprot.
- apb_rsp_o  out  apb_rsp_t  pready, prdata, pslverr.
- obi_req_o  out  obi_req_t  req, a.{addr, we, be, wdata, aid, a_optional}, rready.
- obi_rsp_i  in  obi_rsp_t  gnt, rvalid, r.{rdata, err, rid}.

## Operation
- FSM states: IDLE, REQ, RSP, DONE.
- IDLE: on psel=1 (penable ignored), latch paddr, pwrite, pwdata, be, prot, then go to REQ.
- be latch rule: be = pwrite ? pstrb : '1. Write strobes pass as-is, including all-zero.
- REQ: obi req=1, with a.* driven from the latched registers only. On gnt=1, go to RSP. Otherwise stay in REQ; req and a.* stay stable.
- RSP: req=0. On rvalid=1, register rdata into prdata_q and err into pslverr_q, then go to DONE. rid is not checked.
- DONE: pready=1 for exactly one cycle, prdata=prdata_q, pslverr=pslverr_q, then go to IDLE.
- pready is 0 in every state except DONE.
- rready is tied to 1 when ObiCfg.UseRReady is set.
- a.aid = Aid. All a_optional fields other than prot are '0.
- If psel drops mid-transfer (APB protocol violation), the OBI transaction still completes and DONE still lasts one cycle. The response is then discarded.
- Exactly one OBI transaction is outstanding at any time.
- prdata_q and pslverr_q hold their values until the next rvalid.
- pslverr_q is captured for both reads and writes.

## Timing
- Reset values: state=IDLE, req=0, pready=0, prdata=0, pslverr=0, all latched request registers = 0.
- Reset mid-operation forces IDLE immediately. A late rvalid for the aborted transaction, arriving in IDLE, is ignored. The OBI side must share the reset.
- Cycle numbering: setup phase at T0.
  - REQ at T1.
  - With gnt at T1, RSP at T2.
  - With rvalid at T2, DONE at T3, so pready is seen at T3.
- Minimum APB transfer is 4 cycles: setup plus 3 access cycles.
- Each cycle of gnt or rvalid latency adds one cycle.
- rvalid in the same cycle as gnt is not accepted; it is only sampled in RSP.
- Back-to-back: the next setup phase arrives at DONE+1 in IDLE and is accepted in that same cycle.

## Configuration
- APB_TO_OBI_PROT_EN defined: the latched prot register is driven to a.a_optional.prot.
  - prot[2:1] = pprot[0] ? 2'b11 : 2'b00 (machine vs user).
  - prot[0] = ~pprot[2] (1 = data access).
  - Requires ObiCfg.OptionalCfg.UseProt=1 (init assertion).
- APB_TO_OBI_PROT_EN undefined: no prot register is instantiated. If UseProt is set, a.a_optional.prot is tied to 3'b111 (machine, data).
- Init assertions in both builds:
  - UseAtop, UseMemtype, UseDbg and Integrity are all 0.
  - APB and OBI widths are equal for addr, wdata, rdata and strb/be.

## Test plan
- Read, zero-wait subordinate: psel at T0, paddr=0x1000_0040, pwrite=0; gnt at T1; rvalid at T2 with rdata=0xDEAD_BEEF -> req=1 only at T1, be='1; pready=1 at T3 with prdata=0xDEAD_BEEF, pslverr=0.
- Write with stalls: pwdata=0x1234_5678, pstrb=4'b0011; gnt withheld for 3 cycles; rvalid 2 cycles after gnt -> a.* stable while req=1, be=4'b0011, we=1; pready asserted exactly once, 1 cycle after rvalid.
- Error: rvalid with err=1 -> pready=1 with pslverr=1. The next transfer with err=0 returns pslverr=0.
- Back-to-back: two reads with no idle cycle between them -> second req asserts at DONE+2; each pready carries its own rdata.
- Reset in RSP: assert rst_i, then deliver rvalid after release -> pready stays 0, state is IDLE, and a new transfer then completes normally.
- prot (with APB_TO_OBI_PROT_EN): pprot=3'b001 -> prot=3'b111; pprot=3'b100 -> prot=3'b000. Without the macro, prot is always 3'b111.

Source files
------------

// File: rtl/apb_to_obi.sv
// apb_to_obi: APB subordinate to OBI manager bridge. Each APB transfer is
// replayed as exactly one OBI transaction; the APB access phase completes
// one cycle after the OBI response arrives.
// Build option: define APB_TO_OBI_PROT_EN to forward the APB pprot onto
// a.a_optional.prot (needs OptionalCfg.UseProt=1).
// The minimal obi_pkg below supplies the configuration struct and default
// request/response types so the bridge elaborates on its own.

package obi_pkg;
  typedef struct packed {
    logic UseAtop;
    logic UseMemtype;
    logic UseProt;
    logic UseDbg;
    logic Integrity;
  } obi_optional_cfg_t;

  typedef struct packed {
    logic              UseRReady;
    int unsigned       AddrWidth;
    int unsigned       DataWidth;
    int unsigned       IdWidth;
    obi_optional_cfg_t OptionalCfg;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    UseRReady: 1'b0, AddrWidth: 32, DataWidth: 32, IdWidth: 1, OptionalCfg: '0
  };

  typedef struct packed {
    logic [5:0] atop;
    logic [1:0] memtype;
    logic [2:0] prot;
    logic       dbg;
  } obi_a_optional_t;

  typedef struct packed {
    logic [31:0]     addr;
    logic            we;
    logic [3:0]      be;
    logic [31:0]     wdata;
    logic [0:0]      aid;
    obi_a_optional_t a_optional;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
    logic        rready;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_req_t;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_rsp_t;
endpackage

module apb_to_obi #(
  parameter obi_pkg::obi_cfg_t ObiCfg = obi_pkg::ObiDefaultConfig,
  parameter type obi_req_t = obi_pkg::obi_req_t,
  parameter type obi_rsp_t = obi_pkg::obi_rsp_t,
  parameter type apb_req_t = obi_pkg::apb_req_t,
  parameter type apb_rsp_t = obi_pkg::apb_rsp_t,
  parameter logic [ObiCfg.IdWidth-1:0] Aid = '0
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  apb_req_t apb_req_i,
  output apb_rsp_t apb_rsp_o,
  output obi_req_t obi_req_o,
  input  obi_rsp_t obi_rsp_i
);

  localparam int unsigned AW = ObiCfg.AddrWidth;
  localparam int unsigned DW = ObiCfg.DataWidth;
  localparam int unsigned BW = DW / 8;

  // Elaboration-time configuration checks.
  if (ObiCfg.OptionalCfg.UseAtop || ObiCfg.OptionalCfg.UseMemtype ||
      ObiCfg.OptionalCfg.UseDbg || ObiCfg.OptionalCfg.Integrity) begin : g_chk_optional
    $error("apb_to_obi: atop/memtype/dbg/integrity must be disabled");
  end
  if ($bits(apb_req_i.paddr) != AW || $bits(obi_req_o.a.addr) != AW) begin : g_chk_addr
    $error("apb_to_obi: APB and OBI address widths differ");
  end
  if ($bits(apb_req_i.pwdata) != DW || $bits(obi_req_o.a.wdata) != DW ||
      $bits(apb_rsp_o.prdata) != DW || $bits(obi_rsp_i.r.rdata) != DW) begin : g_chk_data
    $error("apb_to_obi: APB and OBI data widths differ");
  end
  if ($bits(apb_req_i.pstrb) != BW || $bits(obi_req_o.a.be) != BW) begin : g_chk_strb
    $error("apb_to_obi: pstrb and be widths differ");
  end
`ifdef APB_TO_OBI_PROT_EN
  if (!ObiCfg.OptionalCfg.UseProt) begin : g_chk_prot
    $error("apb_to_obi: prot forwarding needs OptionalCfg.UseProt=1");
  end
`endif

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [BW-1:0] be_q, be_d;
  logic [DW-1:0] prdata_q, prdata_d;
  logic          pslverr_q, pslverr_d;

  // penable, rid and any extra struct fields are intentionally ignored.
  logic unused_apb, unused_rsp;
  assign unused_apb = ^apb_req_i;
  assign unused_rsp = ^obi_rsp_i;

  // Next-state and request latching; rvalid is only honoured in RSP, so a
  // response overlapping gnt or arriving after a reset abort is dropped.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    case (state_q)
      IDLE: begin
        if (apb_req_i.psel) begin
          addr_d  = apb_req_i.paddr;
          we_d    = apb_req_i.pwrite;
          wdata_d = apb_req_i.pwdata;
          be_d    = apb_req_i.pwrite ? apb_req_i.pstrb : '1;
          state_d = REQ;
        end
      end
      REQ: if (obi_rsp_i.gnt) state_d = RSP;
      RSP: begin
        if (obi_rsp_i.rvalid) begin
          prdata_d  = obi_rsp_i.r.rdata;
          pslverr_d = obi_rsp_i.r.err;
          state_d   = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched request/response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  logic [2:0] prot_out;

`ifdef APB_TO_OBI_PROT_EN
  logic [2:0] prot_q, prot_d;

  // Translate pprot at setup: privileged -> machine mode, instruction bit inverted to data flag.
  always_comb begin
    prot_d = prot_q;
    if (state_q == IDLE && apb_req_i.psel)
      prot_d = {{2{apb_req_i.pprot[0]}}, ~apb_req_i.pprot[2]};
  end

  // Latched prot register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prot_q <= '0;
    else       prot_q <= prot_d;
  end

  assign prot_out = prot_q;
`else
  // Without forwarding, claim machine-mode data access whenever prot exists.
  assign prot_out = ObiCfg.OptionalCfg.UseProt ? 3'b111 : 3'b000;
`endif

  // Output drive: request fields come only from latched registers.
  always_comb begin
    obi_req_o                     = '0;
    obi_req_o.req                 = (state_q == REQ);
    obi_req_o.rready              = 1'b1;
    obi_req_o.a.addr              = addr_q;
    obi_req_o.a.we                = we_q;
    obi_req_o.a.be                = be_q;
    obi_req_o.a.wdata             = wdata_q;
    obi_req_o.a.aid               = Aid;
    obi_req_o.a.a_optional.prot   = prot_out;

    apb_rsp_o         = '0;
    apb_rsp_o.pready  = (state_q == DONE);
    apb_rsp_o.prdata  = prdata_q;
    apb_rsp_o.pslverr = pslverr_q;
  end

endmodule

// File: tb/tb_apb_to_obi.sv
// Directed bench for apb_to_obi: zero-wait read, stalled write, error
// response, same-cycle gnt/rvalid, back-to-back, reset abort, prot mapping.
module tb_apb_to_obi;
  localparam obi_pkg::obi_cfg_t Cfg = '{
    UseRReady: 1'b1, AddrWidth: 32, DataWidth: 32, IdWidth: 1,
    OptionalCfg: '{UseAtop: 1'b0, UseMemtype: 1'b0, UseProt: 1'b1, UseDbg: 1'b0, Integrity: 1'b0}
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  obi_pkg::apb_req_t apb_req;
  obi_pkg::apb_rsp_t apb_rsp;
  obi_pkg::obi_req_t obi_req;
  obi_pkg::obi_rsp_t obi_rsp;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  apb_to_obi #(
    .ObiCfg(Cfg), .obi_req_t(obi_pkg::obi_req_t), .obi_rsp_t(obi_pkg::obi_rsp_t),
    .apb_req_t(obi_pkg::apb_req_t), .apb_rsp_t(obi_pkg::apb_rsp_t), .Aid(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .apb_req_i(apb_req), .apb_rsp_o(apb_rsp),
    .obi_req_o(obi_req), .obi_rsp_i(obi_rsp)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic setup(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input logic [3:0] strb, input logic [2:0] prot);
    apb_req.psel = 1'b1; apb_req.penable = 1'b0; apb_req.paddr = addr;
    apb_req.pwrite = wr; apb_req.pwdata = wd; apb_req.pstrb = strb; apb_req.pprot = prot;
  endtask

  task automatic test_reset();
    apb_req = '0; obi_rsp = '0; rst = 1'b1;
    tick(); tick();
    checks++; if (obi_req.req !== 1'b0) begin errors++; $display("FAIL rst_req got=%0b exp=0", obi_req.req); end
    checks++; if (apb_rsp.pready !== 1'b0) begin errors++; $display("FAIL rst_pready got=%0b exp=0", apb_rsp.pready); end
    checks++; if (apb_rsp.prdata !== 32'h0 || apb_rsp.pslverr !== 1'b0) begin errors++; $display("FAIL rst_rsp got=%h/%0b exp=0/0", apb_rsp.prdata, apb_rsp.pslverr); end
    checks++; if (obi_req.a.addr !== 32'h0 || obi_req.a.be !== 4'h0 || obi_req.a.wdata !== 32'h0) begin errors++; $display("FAIL rst_regs got=%h/%h/%h exp=0", obi_req.a.addr, obi_req.a.be, obi_req.a.wdata); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_zero_wait();
    setup(32'h1000_0040, 1'b0, 32'h0, 4'h0, 3'b000);
    checks++; if (obi_req.req !== 1'b0) begin errors++; $display("FAIL rd_t0_req got=%0b exp=0", obi_req.req); end
    tick(); // T1
    apb_req.penable = 1'b1; obi_rsp.gnt = 1'b1;
    checks++; if (obi_req.req !== 1'b1) begin errors++; $display("FAIL rd_t1_req got=%0b exp=1", obi_req.req); end
    checks++; if (obi_req.a.addr !== 32'h1000_0040 || obi_req.a.we !== 1'b0 || obi_req.a.be !== 4'hF) begin errors++; $display("FAIL rd_t1_a got=%h/%0b/%h exp=10000040/0/f", obi_req.a.addr, obi_req.a.we, obi_req.a.be); end
    checks++; if (obi_req.a.aid !== 1'b1 || obi_req.rready !== 1'b1) begin errors++; $display("FAIL rd_aid_rready got=%0b/%0b exp=1/1", obi_req.a.aid, obi_req.rready); end
    tick(); // T2
    obi_rsp.gnt = 1'b0; obi_rsp.rvalid = 1'b1; obi_rsp.r.rdata = 32'hDEAD_BEEF; obi_rsp.r.err = 1'b0;
    checks++; if (obi_req.req !== 1'b0 || apb_rsp.pready !== 1'b0) begin errors++; $display("FAIL rd_t2 got=req%0b/rdy%0b exp=0/0", obi_req.req, apb_rsp.pready); end
    tick(); // T3
    obi_rsp.rvalid = 1'b0; apb_req.psel = 1'b0; apb_req.penable = 1'b0;
    checks++; if (apb_rsp.pready !== 1'b1 || apb_rsp.prdata !== 32'hDEAD_BEEF || apb_rsp.pslverr !== 1'b0) begin errors++; $display("FAIL rd_t3 got=%0b/%h/%0b exp=1/deadbeef/0", apb_rsp.pready, apb_rsp.prdata, apb_rsp.pslverr); end
    tick(); // T4
    checks++; if (apb_rsp.pready !== 1'b0) begin errors++; $display("FAIL rd_t4_pready got=%0b exp=0", apb_rsp.pready); end
  endtask

  task automatic test_write_stall();
    int rdy_cnt = 0;
    setup(32'h2000_0008, 1'b1, 32'h1234_5678, 4'b0011, 3'b000);
    tick();
    apb_req.penable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (obi_req.req !== 1'b1 || obi_req.a.addr !== 32'h2000_0008 || obi_req.a.we !== 1'b1 ||
                    obi_req.a.be !== 4'b0011 || obi_req.a.wdata !== 32'h1234_5678) begin
        errors++; $display("FAIL wr_stall%0d got=%0b/%h/%0b/%h/%h exp=1/20000008/1/3/12345678", i, obi_req.req, obi_req.a.addr, obi_req.a.we, obi_req.a.be, obi_req.a.wdata); end
      if (apb_rsp.pready) rdy_cnt++;
      obi_rsp.gnt = (i == 3);
      tick();
    end
    obi_rsp.gnt = 1'b0;
    checks++; if (obi_req.req !== 1'b0) begin errors++; $display("FAIL wr_rsp_req got=%0b exp=0", obi_req.req); end
    for (int i = 0; i < 2; i++) begin
      if (apb_rsp.pready) rdy_cnt++;
      obi_rsp.rvalid = (i == 1); obi_rsp.r.rdata = 32'h0; obi_rsp.r.err = 1'b0;
      tick();
    end
    obi_rsp.rvalid = 1'b0; apb_req.psel = 1'b0; apb_req.penable = 1'b0;
    checks++; if (apb_rsp.pready !== 1'b1 || apb_rsp.pslverr !== 1'b0) begin errors++; $display("FAIL wr_done got=%0b/%0b exp=1/0", apb_rsp.pready, apb_rsp.pslverr); end
    if (apb_rsp.pready) rdy_cnt++;
    tick();
    if (apb_rsp.pready) rdy_cnt++;
    tick();
    if (apb_rsp.pready) rdy_cnt++;
    checks++; if (rdy_cnt !== 1) begin errors++; $display("FAIL wr_pready_count got=%0d exp=1", rdy_cnt); end
  endtask

  task automatic test_error();
    for (int i = 0; i < 2; i++) begin
      setup(32'h3000_0000 + 32'(i * 4), 1'b0, 32'h0, 4'h0, 3'b000);
      tick(); obi_rsp.gnt = 1'b1;
      tick(); obi_rsp.gnt = 1'b0; obi_rsp.rvalid = 1'b1; obi_rsp.r.rdata = 32'hE000_0000 + 32'(i); obi_rsp.r.err = (i == 0);
      tick(); obi_rsp.rvalid = 1'b0; obi_rsp.r.err = 1'b0; apb_req.psel = 1'b0;
      checks++; if (apb_rsp.pready !== 1'b1 || apb_rsp.pslverr !== (i == 0)) begin errors++; $display("FAIL err%0d got=%0b/%0b exp=1/%0b", i, apb_rsp.pready, apb_rsp.pslverr, (i == 0)); end
      tick();
    end
  endtask

  task automatic test_same_cycle_rvalid();
    setup(32'h0000_0030, 1'b0, 32'h0, 4'h0, 3'b000);
    tick(); obi_rsp.gnt = 1'b1; obi_rsp.rvalid = 1'b1; obi_rsp.r.rdata = 32'hBAD0_BAD0;
    tick(); obi_rsp.gnt = 1'b0; obi_rsp.rvalid = 1'b0;
    checks++; if (apb_rsp.pready !== 1'b0 || obi_req.req !== 1'b0) begin errors++; $display("FAIL same_t2 got=%0b/%0b exp=0/0", apb_rsp.pready, obi_req.req); end
    tick();
    checks++; if (apb_rsp.pready !== 1'b0) begin errors++; $display("FAIL same_t3_pready got=%0b exp=0", apb_rsp.pready); end
    obi_rsp.rvalid = 1'b1; obi_rsp.r.rdata = 32'h0000_600D;
    tick(); obi_rsp.rvalid = 1'b0; apb_req.psel = 1'b0;
    checks++; if (apb_rsp.pready !== 1'b1 || apb_rsp.prdata !== 32'h0000_600D) begin errors++; $display("FAIL same_done got=%0b/%h exp=1/0000600d", apb_rsp.pready, apb_rsp.prdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd [2];
    rd[0] = 32'hAAAA_0001; rd[1] = 32'hBBBB_0002;
    for (int i = 0; i < 2; i++) begin
      setup(32'h4000_0000 + 32'(i * 4), 1'b0, 32'h0, 4'h0, 3'b000);
      checks++; if (obi_req.req !== 1'b0 || apb_rsp.pready !== 1'b0) begin errors++; $display("FAIL b2b%0d_setup got=%0b/%0b exp=0/0", i, obi_req.req, apb_rsp.pready); end
      tick(); obi_rsp.gnt = 1'b1;
      checks++; if (obi_req.req !== 1'b1 || obi_req.a.addr !== 32'h4000_0000 + 32'(i * 4)) begin errors++; $display("FAIL b2b%0d_req got=%0b/%h exp=1/%h", i, obi_req.req, obi_req.a.addr, 32'h4000_0000 + 32'(i * 4)); end
      tick(); obi_rsp.gnt = 1'b0; obi_rsp.rvalid = 1'b1; obi_rsp.r.rdata = rd[i];
      tick(); obi_rsp.rvalid = 1'b0; apb_req.psel = 1'b0;
      checks++; if (apb_rsp.pready !== 1'b1 || apb_rsp.prdata !== rd[i]) begin errors++; $display("FAIL b2b%0d_done got=%0b/%h exp=1/%h", i, apb_rsp.pready, apb_rsp.prdata, rd[i]); end
      tick();
    end
  endtask

  task automatic test_reset_rsp();
    setup(32'h5000_0000, 1'b0, 32'h0, 4'h0, 3'b000);
    tick(); obi_rsp.gnt = 1'b1;
    tick(); obi_rsp.gnt = 1'b0; apb_req.psel = 1'b0;
    rst = 1'b1; #1;
    checks++; if (obi_req.req !== 1'b0 || apb_rsp.pready !== 1'b0) begin errors++; $display("FAIL rstrsp_async got=%0b/%0b exp=0/0", obi_req.req, apb_rsp.pready); end
    tick(); tick(); rst = 1'b0;
    obi_rsp.rvalid = 1'b1; obi_rsp.r.rdata = 32'hFFFF_FFFF;
    tick(); obi_rsp.rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (apb_rsp.pready !== 1'b0 || obi_req.req !== 1'b0 || apb_rsp.prdata !== 32'h0) begin errors++; $display("FAIL rstrsp_late%0d got=%0b/%0b/%h exp=0/0/0", i, apb_rsp.pready, obi_req.req, apb_rsp.prdata); end
      tick();
    end
    setup(32'h5000_0010, 1'b0, 32'h0, 4'h0, 3'b000);
    tick(); obi_rsp.gnt = 1'b1;
    checks++; if (obi_req.req !== 1'b1) begin errors++; $display("FAIL rstrsp_new_req got=%0b exp=1", obi_req.req); end
    tick(); obi_rsp.gnt = 1'b0; obi_rsp.rvalid = 1'b1; obi_rsp.r.rdata = 32'h5A5A_A5A5;
    tick(); obi_rsp.rvalid = 1'b0; apb_req.psel = 1'b0;
    checks++; if (apb_rsp.pready !== 1'b1 || apb_rsp.prdata !== 32'h5A5A_A5A5) begin errors++; $display("FAIL rstrsp_new_done got=%0b/%h exp=1/5a5aa5a5", apb_rsp.pready, apb_rsp.prdata); end
    tick();
  endtask

  task automatic test_prot();
    logic [2:0] pp [2];
    logic [2:0] exp [2];
    pp[0] = 3'b001; pp[1] = 3'b100;
`ifdef APB_TO_OBI_PROT_EN
    exp[0] = 3'b111; exp[1] = 3'b000;
`else
    exp[0] = 3'b111; exp[1] = 3'b111;
`endif
    for (int i = 0; i < 2; i++) begin
      setup(32'h6000_0000, 1'b0, 32'h0, 4'h0, pp[i]);
      tick(); obi_rsp.gnt = 1'b1;
      if (i == 1) apb_req.psel = 1'b0; // protocol violation: transfer must still finish
      checks++; if (obi_req.a.a_optional.prot !== exp[i]) begin errors++; $display("FAIL prot%0d got=%b exp=%b", i, obi_req.a.a_optional.prot, exp[i]); end
      tick(); obi_rsp.gnt = 1'b0; obi_rsp.rvalid = 1'b1; obi_rsp.r.rdata = 32'h7;
      tick(); obi_rsp.rvalid = 1'b0; apb_req.psel = 1'b0;
      checks++; if (apb_rsp.pready !== 1'b1) begin errors++; $display("FAIL prot%0d_done got=%0b exp=1", i, apb_rsp.pready); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_stall();
    test_error();
    test_same_cycle_rvalid();
    test_back_to_back();
    test_reset_rsp();
    test_prot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
